// File: rtl/wb_pkg.sv
// Shared definitions for the store write buffer.
//   ADDR_W_DEF / DATA_W_DEF : default byte-address and store-word widths
//   drain_state_e           : drain FSM encoding (StIdle = 0, StBusy = 1)
//   entry_t                 : one buffered store {valid, addr, data} at default widths
package wb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } drain_state_e;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } entry_t;

endpackage

// File: rtl/wb_entry_array.sv
// Entry storage for the store write buffer: DEPTH x {valid, word address, data}.
//   clk_i, reset_i          : clock, synchronous active-high reset
//   we_i/w_idx_i/w_*_i      : write port (sets valid)
//   clr_i/clr_idx_i         : valid-clear port (entry drained)
//   hd_idx_i -> hd_*_o      : combinational read port used to load the drain registers
//   base_i                  : index of the oldest entry (head)
//   fwd_addr_i -> fwd_*_o   : youngest-match forwarding search
module wb_entry_array
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned WADDR_W = 30,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               we_i,
  input  logic [PTR_W-1:0]   w_idx_i,
  input  logic [WADDR_W-1:0] w_addr_i,
  input  logic [DATA_W-1:0]  w_data_i,
  input  logic               clr_i,
  input  logic [PTR_W-1:0]   clr_idx_i,
  input  logic [PTR_W-1:0]   hd_idx_i,
  output logic [WADDR_W-1:0] hd_addr_o,
  output logic [DATA_W-1:0]  hd_data_o,
  input  logic [PTR_W-1:0]   base_i,
  input  logic [WADDR_W-1:0] fwd_addr_i,
  output logic               fwd_hit_o,
  output logic [DATA_W-1:0]  fwd_data_o
);

  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [WADDR_W-1:0] addr_q [DEPTH];
  logic [WADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0]  data_q [DEPTH];
  logic [DATA_W-1:0]  data_d [DEPTH];
  logic [PTR_W-1:0]   idx;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d[clr_idx_i] = 1'b0;
    end
    if (we_i) begin
      valid_d[w_idx_i] = 1'b1;
      addr_d[w_idx_i]  = w_addr_i;
      data_d[w_idx_i]  = w_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign hd_addr_o = addr_q[hd_idx_i];
  assign hd_data_o = data_q[hd_idx_i];

  // Walk from oldest to youngest; a later match overrides, so the youngest wins.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    idx        = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = base_i + PTR_W'(i);
      if (valid_q[idx] && (addr_q[idx] == fwd_addr_i)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = data_q[idx];
      end
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer between the data cache and backing data memory.
// Stores are queued in one cycle, drained in order over mem_req/mem_ack, and the
// youngest buffered value for a word is forwarded to loads.
//   clk, reset                 : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data      : store from the cache; wr_full stalls upstream
//   rd_addr -> rd_hit/rd_data  : load forwarding lookup (word granularity)
//   mem_req/mem_addr/mem_data  : drain request to memory, mem_ack accepts it
//   empty, count               : occupancy status
module store_write_buffer
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_full,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_hit,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mem_ack,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned WADDR_W = ADDR_W - 2;

  drain_state_e       state_q, state_d;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d, ld_idx;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WADDR_W-1:0] mem_waddr_q, mem_waddr_d, hd_addr, ld_addr;
  logic [DATA_W-1:0]  mem_data_q, mem_data_d, hd_data, ld_data;
  logic               accept, pop;
  logic               unused_offsets;

  // Byte offsets play no part in matching or draining.
  assign unused_offsets = ^{wr_addr[1:0], rd_addr[1:0]};

  assign wr_full  = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign mem_req  = (state_q == StBusy);
  assign mem_addr = {mem_waddr_q, 2'b00};
  assign mem_data = mem_data_q;

  wb_entry_array #(
    .DEPTH   (DEPTH),
    .WADDR_W (WADDR_W),
    .DATA_W  (DATA_W)
  ) u_entries (
    .clk_i      (clk),
    .reset_i    (reset),
    .we_i       (accept),
    .w_idx_i    (tail_q),
    .w_addr_i   (wr_addr[ADDR_W-1:2]),
    .w_data_i   (wr_data),
    .clr_i      (pop),
    .clr_idx_i  (head_q),
    .hd_idx_i   (ld_idx),
    .hd_addr_o  (hd_addr),
    .hd_data_o  (hd_data),
    .base_i     (head_q),
    .fwd_addr_i (rd_addr[ADDR_W-1:2]),
    .fwd_hit_o  (rd_hit),
    .fwd_data_o (rd_data)
  );

  always_comb begin
    accept = wr_en && !wr_full;
    pop    = (state_q == StBusy) && mem_ack;
    tail_d = accept ? tail_q + PTR_W'(1) : tail_q;
    head_d = pop ? head_q + PTR_W'(1) : head_q;

    unique case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Entry to load into the drain registers: the head when starting, the one
    // after it when a pop is completing.
    ld_idx = (state_q == StBusy) ? head_q + PTR_W'(1) : head_q;
    // A single remaining entry popped while a new store lands right behind it:
    // that store is not in the array yet, so take it straight from the write port.
    if (accept && (tail_q == ld_idx)) begin
      ld_addr = wr_addr[ADDR_W-1:2];
      ld_data = wr_data;
    end else begin
      ld_addr = hd_addr;
      ld_data = hd_data;
    end

    state_d     = state_q;
    mem_waddr_d = mem_waddr_q;
    mem_data_d  = mem_data_q;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          state_d     = StBusy;
          mem_waddr_d = ld_addr;
          mem_data_d  = ld_data;
        end
      end
      StBusy: begin
        if (mem_ack) begin
          if (count_d != '0) begin
            mem_waddr_d = ld_addr;
            mem_data_d  = ld_data;
          end else begin
            state_d     = StIdle;
            mem_waddr_d = '0;
            mem_data_d  = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      mem_waddr_q <= '0;
      mem_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      mem_waddr_q <= mem_waddr_d;
      mem_data_q  <= mem_data_d;
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed cases plus random traffic,
// scored against a queue model of the buffer contents.
module tb_store_write_buffer;
  import wb_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [31:0] wr_addr, wr_data, rd_addr;
  logic        wr_full, rd_hit, mem_req, mem_ack, empty;
  logic [31:0] rd_data, mem_addr, mem_data;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  entry_t model_q[$];  // current buffer contents, oldest first
  entry_t exp_q[$];    // expected drain sequence

  store_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_full  (wr_full),
    .rd_addr  (rd_addr),
    .rd_hit   (rd_hit),
    .rd_data  (rd_data),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_ack  (mem_ack),
    .empty    (empty),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void fwd_model(input logic [31:0] a, output logic hit,
                                    output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    foreach (model_q[i]) begin
      if (model_q[i].addr[31:2] == a[31:2]) begin
        hit = 1'b1;
        d   = model_q[i].data;
      end
    end
  endfunction

  task automatic check_outputs();
    logic        h;
    logic [31:0] d;
    fwd_model(rd_addr, h, d);
    check("count", count, model_q.size());
    check("empty", empty, model_q.size() == 0);
    check("wr_full", wr_full, model_q.size() == DEPTH);
    check("rd_hit", rd_hit, h);
    check("rd_data", rd_data, d);
    if (model_q.size() == 0) check("mem_req_idle", mem_req, 1'b0);
  endtask

  // Drive one cycle: inputs applied now, outputs checked mid-cycle, model advanced
  // to the state after the coming rising edge. Returns 2 time units after that edge.
  task automatic step(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                      input logic ack, input logic rst);
    entry_t e;
    logic   acc, pp;
    wr_en = we; wr_addr = wa; wr_data = wd; mem_ack = ack; reset = rst;
    @(negedge clk);
    #1;
    check_outputs();
    if (rst) begin
      model_q.delete();
      exp_q.delete();
    end else begin
      acc = we && (model_q.size() < DEPTH);
      pp  = mem_req && ack;
      if (pp) void'(model_q.pop_front());
      if (acc) begin
        e.valid = 1'b1;
        e.addr  = {wa[31:2], 2'b00};
        e.data  = wd;
        model_q.push_back(e);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic ack);
    step(1'b0, 32'h0, 32'h0, ack, 1'b0);
  endtask

  task automatic drain_all();
    for (int i = 0; i < 20 && model_q.size() != 0; i++) idle(1'b1);
    idle(1'b0);
    check("drained_empty", empty, 1'b1);
  endtask

  // Scoreboard monitor: a handshake seen mid-cycle retires the oldest expected store.
  initial begin : monitor
    logic        hold_v;
    logic [31:0] h_addr, h_data;
    entry_t      e;
    hold_v = 1'b0;
    h_addr = '0;
    h_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("req_held", mem_req, 1'b1);
          check("addr_stable", mem_addr, h_addr);
          check("data_stable", mem_data, h_data);
        end
        if (mem_req && mem_ack) begin
          if (exp_q.size() == 0) begin
            check("drain_unexpected", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("drain_addr", mem_addr, e.addr);
            check("drain_data", mem_data, e.data);
          end
          hold_v = 1'b0;
        end else if (mem_req) begin
          hold_v = 1'b1;
          h_addr = mem_addr;
          h_data = mem_data;
        end else begin
          hold_v = 1'b0;
        end
      end
    end
  end

  initial begin
    reset = 1'b1; wr_en = 1'b1; wr_addr = 32'h100; wr_data = 32'h5; mem_ack = 1'b0;
    rd_addr = 32'h100;
    repeat (2) @(posedge clk);
    #2;
    check("rst_empty", empty, 1'b1);
    check("rst_count", count, 0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_wr_full", wr_full, 1'b0);
    check("rst_rd_hit", rd_hit, 1'b0);
    check("rst_rd_data", rd_data, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_data, 0);

    // Single drain with latency.
    rd_addr = 32'h0;
    step(1'b1, 32'h29, 32'hDEADBEEF, 1'b0, 1'b0);
    check("lat_req_edge1", mem_req, 1'b0);
    idle(1'b0);
    check("lat_req_edge2", mem_req, 1'b1);
    check("single_addr", mem_addr, 32'h28);
    check("single_data", mem_data, 32'hDEADBEEF);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    check("single_empty", empty, 1'b1);
    check("single_req_low", mem_req, 1'b0);

    // Fill to full, overflow write dropped, back-to-back drain.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h10 + 32'(4 * i), 32'(i + 1), 1'b0, 1'b0);
    step(1'b1, 32'h20, 32'h5, 1'b0, 1'b0);
    check("full_flag", wr_full, 1'b1);
    check("full_count", count, 4);
    for (int i = 0; i < 4; i++) begin
      check("b2b_req", mem_req, 1'b1);
      idle(1'b1);
      check("b2b_count", count, 3 - i);
    end
    idle(1'b0);

    // Forwarding picks the youngest match.
    step(1'b1, 32'h40, 32'h11111111, 1'b0, 1'b0);
    step(1'b1, 32'h40, 32'h22222222, 1'b0, 1'b0);
    rd_addr = 32'h42;
    #1;
    check("fwd_hit", rd_hit, 1'b1);
    check("fwd_data", rd_data, 32'h22222222);
    rd_addr = 32'h44;
    #1;
    check("fwd_miss_hit", rd_hit, 1'b0);
    check("fwd_miss_data", rd_data, 0);
    rd_addr = 32'h80;
    step(1'b1, 32'h80, 32'h33333333, 1'b0, 1'b0);  // same-cycle write not forwarded
    drain_all();

    // Accept and pop together.
    step(1'b1, 32'h50, 32'hA0, 1'b0, 1'b0);
    step(1'b1, 32'h54, 32'hA1, 1'b0, 1'b0);
    step(1'b1, 32'h60, 32'hA2, 1'b1, 1'b0);
    check("simul_count2", count, 2);
    drain_all();
    step(1'b1, 32'h70, 32'hB0, 1'b0, 1'b0);
    idle(1'b0);
    step(1'b1, 32'h74, 32'hB1, 1'b1, 1'b0);
    check("simul_count1", count, 1);
    check("simul_req", mem_req, 1'b1);
    drain_all();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h80 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'h90, 32'hCC, 1'b1, 1'b0);
    check("full_pop_count", count, 3);
    drain_all();

    // Reset together with an ack mid-drain.
    for (int i = 0; i < 3; i++) step(1'b1, 32'hA0 + 32'(4 * i), 32'hD0 + 32'(i), 1'b0, 1'b0);
    check("mid_req", mem_req, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    check("mid_rst_count", count, 0);
    check("mid_rst_req", mem_req, 1'b0);
    repeat (4) idle(1'b1);

    // Random traffic on a small address window to provoke matches.
    for (int i = 0; i < 400; i++) begin
      rd_addr = 32'h100 + 32'($urandom_range(0, 8) * 4) + 32'($urandom_range(0, 3));
      step($urandom_range(0, 1) == 1,
           32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
           $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 59) == 0);
    end
    drain_all();
    check("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
